// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin arbiter driving a registered mux8 select; optional hold limit via MUX8_ARB_HOLD_LIMIT_EN
module mux8_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       valid,
  output logic       y
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] s_q, s_d, ptr_q, ptr_d;
  logic       valid_q, valid_d, y_q, y_d;
  logic [7:0] others;
  logic [2:0] start, pick, idx;
  logic       found, hold_expired, rearb;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign hold_expired = (state_q == GRANT) && (cnt_q == CW'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif
  // The current owner is excluded so re-arbitration always moves on; in IDLE gnt_q is zero
  assign others = req & ~gnt_q;
  assign start  = (state_q == IDLE) ? ptr_q : s_q + 3'd1;
  assign rearb  = (state_q == IDLE) || !req[s_q] || (hold_expired && |others);
  // Round-robin search: scanning from the far end lets the nearest set bit win
  always_comb begin
    found = 1'b0;
    pick  = start;
    idx   = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (others[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  // Next-state: hold the owner, hand over without a bubble, or fall back to IDLE
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    y_d     = valid_q & d[s_q];
    if (rearb) begin
      state_d = found ? GRANT : IDLE;
      gnt_d   = found ? 8'b1 << pick : 8'h00;
      s_d     = found ? pick : 3'd0;
      valid_d = found;
      ptr_d   = found ? pick + 3'd1 : ptr_q;
    end
  end
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  // Consecutive-cycle count for the current owner, saturating when nobody else waits
  always_comb begin
    cnt_d = (rearb || state_d == IDLE) ? '0 : (hold_expired ? cnt_q : cnt_q + 1'b1);
  end
  // Hold counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif
  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      s_q     <= 3'd0;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
    end
  end
  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign y     = y_q;
endmodule
